// File: rtl/mux32_pkg.sv
// Shared definitions for the execute-stage operand-select mux.
// Optional parity output is enabled by defining MUX32_PARITY_EN.
package mux32_pkg;

    localparam int XLEN = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Even parity bit: this is the XOR reduction of the input word.
    function automatic logic parity_of(input logic [XLEN-1:0] word);
        return ^word;
    endfunction

endpackage : mux32_pkg

// File: rtl/mux2_core.sv
// Purely combinational WIDTH-bit 2:1 mux; any sel other than SEL_B picks a.
module mux2_core
    import mux32_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = (sel == SEL_B) ? b : a;
    end

endmodule : mux2_core

// File: rtl/mux32_reg.sv
// Operand-select mux with zero-latency output y and an enable/flush register y_q.
// Define MUX32_PARITY_EN to add the registered even-parity output y_q_par.
module mux32_reg
    import mux32_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_valid
`ifdef MUX32_PARITY_EN
    ,
    output logic             y_q_par
`endif
);

    logic [WIDTH-1:0] y_q_d;
    logic             valid_q;
    logic             valid_d;

    mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (y)
    );

    // Flush outranks enable; with neither asserted, the register holds.
    always_comb begin
        y_q_d   = y_q;
        valid_d = valid_q;
        if (flush) begin
            y_q_d   = RESET_VAL;
            valid_d = 1'b0;
        end else if (en) begin
            y_q_d   = y;
            valid_d = 1'b1;
        end
    end

    // NOTE: the reset check lives inside the clocked block, so it takes effect only at an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_q_d;
            valid_q <= valid_d;
        end
    end

    assign y_q_valid = valid_q;

`ifdef MUX32_PARITY_EN
    logic par_q;
    logic par_d;

    always_comb begin
        par_d = par_q;
        if (flush) begin
            par_d = ^RESET_VAL;
        end else if (en) begin
            par_d = ^y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= ^RESET_VAL;
        end else begin
            par_q <= par_d;
        end
    end

    assign y_q_par = par_q;
`endif

endmodule : mux32_reg

// File: tb/tb_mux32_reg.sv
// Directed self-checking bench for mux32_reg; parity checks run when MUX32_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_mux32_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic        en;
    logic        flush;
    logic [31:0] y;
    logic [31:0] y_q;
    logic        y_q_valid;
`ifdef MUX32_PARITY_EN
    logic        y_q_par;
`endif

    int checks   = 0;
    int failures = 0;

    mux32_reg dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .en        (en),
        .flush     (flush),
        .y         (y),
        .y_q       (y_q),
        .y_q_valid (y_q_valid)
`ifdef MUX32_PARITY_EN
        ,
        .y_q_par   (y_q_par)
`endif
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; flush = 1'b0; sel = 1'b0; a = '0; b = '0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (y_q !== 32'h0) begin
            failures++;
            $display("FAIL reset_y_q: got %h expected %h", y_q, 32'h0);
        end
        checks++;
        if (y_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected %b", y_q_valid, 1'b0);
        end
        // Without an enable, y_q stays at the reset value after deassertion.
        a = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (y_q !== 32'h0 || y_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got %h/%b expected %h/%b", y_q, y_q_valid, 32'h0, 1'b0);
        end
    endtask

    task automatic test_comb_toggle();
        logic [3:0]  sels = 4'b1010;
        logic [31:0] exp_y;
        a = 32'h0000_0000;
        b = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            sel = sels[i];
            exp_y = sels[i] ? 32'h1 : 32'h0;
            #1;
            checks++;
            if (y !== exp_y) begin
                failures++;
                $display("FAIL comb_toggle[%0d]: got %h expected %h", i, y, exp_y);
            end
            #9;
        end
    endtask

    task automatic test_full_width();
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        sel = 1'b0;
        #1;
        checks++;
        if (y !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL full_width_a: got %h expected %h", y, 32'hDEAD_BEEF);
        end
        sel = 1'b1;
        #1;
        checks++;
        if (y !== 32'h1234_5678) begin
            failures++;
            $display("FAIL full_width_b: got %h expected %h", y, 32'h1234_5678);
        end
    endtask

    task automatic test_load_stall();
        en = 1'b1; sel = 1'b1; b = 32'hA5A5_A5A5;
        tick();
        checks++;
        if (y_q !== 32'hA5A5_A5A5 || y_q_valid !== 1'b1) begin
            failures++;
            $display("FAIL load: got %h/%b expected %h/%b", y_q, y_q_valid, 32'hA5A5_A5A5, 1'b1);
        end
        en = 1'b0; b = 32'h0;
        #1;
        checks++;
        if (y !== 32'h0) begin
            failures++;
            $display("FAIL stall_y_tracks: got %h expected %h", y, 32'h0);
        end
        tick();
        tick();
        checks++;
        if (y_q !== 32'hA5A5_A5A5 || y_q_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: got %h/%b expected %h/%b", y_q, y_q_valid, 32'hA5A5_A5A5, 1'b1);
        end
    endtask

    task automatic test_flush_priority();
        flush = 1'b1; en = 1'b1; sel = 1'b1; b = 32'h5555_5555;
        tick();
        flush = 1'b0; en = 1'b0;
        checks++;
        if (y_q !== 32'h0 || y_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_priority: got %h/%b expected %h/%b", y_q, y_q_valid, 32'h0, 1'b0);
        end
        // Flush with en low also clears a loaded value.
        en = 1'b1; sel = 1'b0; a = 32'h0BAD_F00D;
        tick();
        en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (y_q !== 32'h0 || y_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_en: got %h/%b expected %h/%b", y_q, y_q_valid, 32'h0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        logic [31:0] bv [3] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        logic [2:0]  sv = 3'b101;
        logic [31:0] exp_q;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = av[i]; b = bv[i]; sel = sv[i];
            exp_q = sv[i] ? bv[i] : av[i];
            tick();
            checks++;
            if (y_q !== exp_q || y_q_valid !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %h/%b expected %h/%b", i, y_q, y_q_valid, exp_q, 1'b1);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_sync_reset();
        en = 1'b1; sel = 1'b0; a = 32'hCAFE_F00D; b = 32'h0F0F_0F0F;
        tick();
        // Assert reset between edges, keeping en high and changing the select.
        reset = 1'b1; sel = 1'b1;
        #1;
        checks++;
        if (y_q !== 32'hCAFE_F00D || y_q_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_between_edges: got %h/%b expected %h/%b", y_q, y_q_valid, 32'hCAFE_F00D, 1'b1);
        end
        checks++;
        if (y !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL reset_y_unaffected: got %h expected %h", y, 32'h0F0F_0F0F);
        end
        tick();
        checks++;
        if (y_q !== 32'h0 || y_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_at_edge: got %h/%b expected %h/%b", y_q, y_q_valid, 32'h0, 1'b0);
        end
        checks++;
        if (y !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL reset_y_after_edge: got %h expected %h", y, 32'h0F0F_0F0F);
        end
        reset = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (y_q !== 32'h0 || y_q_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_hold: got %h/%b expected %h/%b", y_q, y_q_valid, 32'h0, 1'b0);
        end
    endtask

`ifdef MUX32_PARITY_EN
    task automatic test_parity();
        en = 1'b1; sel = 1'b0; a = 32'h0000_0007;
        tick();
        checks++;
        if (y_q_par !== 1'b1) begin
            failures++;
            $display("FAIL parity_7: got %b expected %b", y_q_par, 1'b1);
        end
        a = 32'h0000_0003;
        tick();
        checks++;
        if (y_q_par !== 1'b0) begin
            failures++;
            $display("FAIL parity_3: got %b expected %b", y_q_par, 1'b0);
        end
        a = 32'h8000_0000;
        tick();
        en = 1'b0; a = 32'h0000_0003;
        tick();
        checks++;
        if (y_q_par !== 1'b1) begin
            failures++;
            $display("FAIL parity_hold: got %b expected %b", y_q_par, 1'b1);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (y_q_par !== 1'b0) begin
            failures++;
            $display("FAIL parity_flush: got %b expected %b", y_q_par, 1'b0);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_comb_toggle();
        test_full_width();
        test_load_stall();
        test_flush_priority();
        test_back_to_back();
        test_sync_reset();
`ifdef MUX32_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux32_reg
